// File: rtl/btn_sched_pkg.sv
// Shared definitions for the button event scheduler: history patterns,
// a constant-safe clog2 helper and the default event code type.
package btn_sched_pkg;

    localparam logic [2:0] PRESS_PAT = 3'b011;
    localparam logic [2:0] HELD_PAT  = 3'b111;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int N_BTN_DEF  = 4;
    localparam int CODE_W_DEF = clog2(N_BTN_DEF);

    typedef logic [CODE_W_DEF-1:0] evt_code_t;

endpackage

// File: rtl/btn_press_detect.sv
// Per-channel press detector: a 3-sample shift history clocked by the sample
// tick flags a press on the low-high-high pattern. With
// BTN_SCHED_AUTOREPEAT_EN defined, a hold counter also emits repeat presses
// while the button stays down.
module btn_press_detect
    import btn_sched_pkg::*;
`ifdef BTN_SCHED_AUTOREPEAT_EN
#(
    parameter int REPEAT_DLY  = 32,
    parameter int REPEAT_RATE = 8
)
`endif
(
    input  logic Clk,
    input  logic Reset,
    input  logic tick_i,
    input  logic btn_i,
    output logic press_o
);

    logic [2:0] hist_q;
    logic [2:0] hist_d;

    // Shift the newest sample into bit 0 on every tick
    always_comb begin
        hist_d = hist_q;
        if (tick_i) begin
            hist_d = {hist_q[1:0], btn_i};
        end
    end

    // History register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

`ifdef BTN_SCHED_AUTOREPEAT_EN
    localparam int RPT_W = clog2(REPEAT_DLY + 1);

    logic [RPT_W-1:0] hold_q;
    logic [RPT_W-1:0] hold_d;
    logic             repeat_hit;

    // Count ticks spent fully held; on reaching the delay fire a repeat and
    // reload so that later repeats come every REPEAT_RATE ticks
    always_comb begin
        hold_d     = hold_q;
        repeat_hit = 1'b0;
        if (tick_i) begin
            if (hist_d == HELD_PAT) begin
                if (hold_q + 1'b1 == RPT_W'(REPEAT_DLY)) begin
                    repeat_hit = 1'b1;
                    hold_d     = RPT_W'(REPEAT_DLY - REPEAT_RATE);
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end else begin
                hold_d = '0;
            end
        end
    end

    // Hold counter register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign press_o = (tick_i && (hist_d == PRESS_PAT)) || repeat_hit;
`else
    assign press_o = tick_i && (hist_d == PRESS_PAT);
`endif

endmodule

// File: rtl/btn_event_scheduler.sv
// Button front-end: divided sample tick, per-channel press detection,
// pending latches, round-robin arbitration and an event FIFO presented over
// valid/ready. Optional auto-repeat is enabled by BTN_SCHED_AUTOREPEAT_EN.
module btn_event_scheduler
    import btn_sched_pkg::*;
#(
    parameter int N_BTN      = N_BTN_DEF,
    parameter int CODE_W     = CODE_W_DEF,
    parameter int SAMPLE_DIV = 16,
    parameter int FIFO_DEPTH = 4
`ifdef BTN_SCHED_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DLY  = 32,
    parameter int REPEAT_RATE = 8
`endif
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_BTN-1:0]  btn_raw,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CODE_W-1:0] evt_code,
    output logic [N_BTN-1:0]  pending,
    output logic              overflow
);

    localparam int DIV_W = clog2(SAMPLE_DIV);
    localparam int PTR_W = clog2(FIFO_DEPTH);
    localparam int CNT_W = clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = CODE_W + 1;

    logic [DIV_W-1:0]  div_q, div_d;
    logic [N_BTN-1:0]  pending_q, pending_d;
    logic [CODE_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [CODE_W-1:0] fifo_q [FIFO_DEPTH];

    logic              tick;
    logic [N_BTN-1:0]  press;
    logic              pop;
    logic              can_accept;
    logic              grant_found;
    logic              grant_any;
    logic [CODE_W-1:0] grant_idx;
    logic [N_BTN-1:0]  grant_vec;
    logic [IDX_W-1:0]  scan_idx;

    assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_press_detect
`ifdef BTN_SCHED_AUTOREPEAT_EN
        #(
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_RATE(REPEAT_RATE)
        )
`endif
        u_detect (
            .Clk    (Clk),
            .Reset  (Reset),
            .tick_i (tick),
            .btn_i  (btn_raw[i]),
            .press_o(press[i])
        );
    end

    assign evt_valid  = (count_q != '0);
    assign evt_code   = evt_valid ? fifo_q[rd_q] : '0;
    assign pending    = pending_q;
    assign overflow   = overflow_q;
    assign pop        = evt_valid && evt_ready;
    assign can_accept = (count_q < CNT_W'(FIFO_DEPTH)) || pop;
    assign grant_any  = grant_found && can_accept;

    // Round-robin pick: first pending channel at or after rr_q, cyclically
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_BTN; k++) begin
            scan_idx = {1'b0, rr_q} + IDX_W'(k);
            if (scan_idx >= IDX_W'(N_BTN)) begin
                scan_idx = scan_idx - IDX_W'(N_BTN);
            end
            if (!grant_found && pending_q[scan_idx[CODE_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[CODE_W-1:0];
            end
        end
        grant_vec = '0;
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Next state for tick divider, pending latches, pointers and FIFO count
    always_comb begin
        div_d      = tick ? '0 : div_q + 1'b1;
        pending_d  = (pending_q & ~grant_vec) | press;
        overflow_d = overflow_q | (|(press & pending_q & ~grant_vec));
        rr_d       = rr_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        if (grant_any) begin
            rr_d = (grant_idx == CODE_W'(N_BTN - 1)) ? '0 : grant_idx + 1'b1;
            wr_d = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (grant_any && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!grant_any && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers and FIFO storage
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q      <= '0;
            pending_q  <= '0;
            rr_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                fifo_q[e] <= '0;
            end
        end else begin
            div_q      <= div_d;
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (grant_any) begin
                fifo_q[wr_q] <= grant_idx;
            end
        end
    end

endmodule
